// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: 2-stage valid/ready pipeline applying one of four bitwise
// functions to a, b, c, with a saturating count of all-ones x transfers.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] match_cnt
);
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a, s1_b, s1_c;
    logic [1:0]       s1_mode;
    logic             s2_adv, in_fire, out_fire;
    logic [WIDTH-1:0] fx, fy;

    assign s2_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_adv;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // operands are captured only on a transfer so idle-cycle junk never enters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
            s1_mode  <= '0;
        end else begin
            s1_valid <= in_fire || (s1_valid && !s2_adv);
            if (in_fire) begin
                s1_a    <= in_a;
                s1_b    <= in_b;
                s1_c    <= in_c;
                s1_mode <= in_mode;
            end
        end
    end

    always_comb begin
        fx = s1_a;
        fy = s1_b;
        case (s1_mode)
            2'b00: begin
                fx = ~s1_c ^ (s1_a | s1_b);
                fy = s1_a & s1_b;
            end
            2'b01: begin
                fx = s1_c ^ (s1_a & s1_b);
                fy = s1_a ^ s1_b;
            end
            2'b10: begin
                fx = ~(s1_a | s1_b | s1_c);
                fy = (s1_a & s1_b) | (s1_a & s1_c) | (s1_b & s1_c);
            end
            default: begin
                fx = s1_a;
                fy = s1_b;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
        end else begin
            out_valid <= s2_adv || (out_valid && !out_ready);
            if (s2_adv) begin
                out_x <= fx;
                out_y <= fy;
            end
        end
    end

    // clear wins over a same-cycle increment; saturate instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            match_cnt <= '0;
        else if (clr_cnt)
            match_cnt <= '0;
        else if (out_fire && (&out_x) && !(&match_cnt))
            match_cnt <= match_cnt + 1'b1;
    end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed and randomized checks of logic_unit_pipe against
// a queue-based transaction model; a CNT_W=4 copy exercises counter saturation.
module tb_logic_unit_pipe;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           t;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         clr_cnt = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0, in_c = '0;
    logic [1:0]   in_mode = '0;
    logic         in_ready, out_valid, in_ready_s, out_valid_s;
    logic [W-1:0] out_x, out_y, out_x_s, out_y_s;
    logic [15:0]  match_cnt;
    logic [3:0]   match_cnt_s;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int cnt16 = 0;
    int cnt4 = 0;
    beat_t q[$];
    beat_t obs[$];

    logic [W-1:0] fx_lit[4] = '{8'hA9, 8'h6A, 8'h01, 8'hF0};
    logic [W-1:0] fy_lit[4] = '{8'hC0, 8'h3C, 8'hE8, 8'hCC};
    logic [W-1:0] bp_lit[3] = '{8'h11, 8'h22, 8'h33};

    logic_unit_pipe #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
        .clr_cnt(clr_cnt), .match_cnt(match_cnt)
    );

    logic_unit_pipe #(.WIDTH(W), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_mode(in_mode),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_x(out_x_s), .out_y(out_y_s),
        .clr_cnt(clr_cnt), .match_cnt(match_cnt_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // per-bit truth of each function, counting ones rather than using gate forms
    function automatic logic [2*W-1:0] ref_xy(input logic [1:0] m, input logic [W-1:0] a, b, c);
        logic [W-1:0] x, y;
        for (int i = 0; i < W; i++) begin
            int ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
            case (m)
                2'd0: begin x[i] = (c[i] == (a[i] || b[i])); y[i] = a[i] && b[i]; end
                2'd1: begin x[i] = (c[i] != (a[i] && b[i])); y[i] = (a[i] != b[i]); end
                2'd2: begin x[i] = (ones == 0); y[i] = (ones >= 2); end
                default: begin x[i] = a[i]; y[i] = b[i]; end
            endcase
        end
        return {x, y};
    endfunction

    // model: head of queue is visible once it has been inside for two edges
    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                cnt16 = 0;
                cnt4 = 0;
            end else begin
                logic exp_ov, exp_ir, ofire;
                logic [2*W-1:0] r;
                exp_ov = (q.size() > 0) && (cyc - q[0].t >= 2);
                exp_ir = (q.size() < 2) || out_ready;
                check("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
                check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
                check("sat_in_ready", {31'd0, in_ready_s}, {31'd0, exp_ir});
                check("sat_out_valid", {31'd0, out_valid_s}, {31'd0, exp_ov});
                if (exp_ov) begin
                    check("out_x", {24'd0, out_x}, {24'd0, q[0].x});
                    check("out_y", {24'd0, out_y}, {24'd0, q[0].y});
                    check("sat_out_x", {24'd0, out_x_s}, {24'd0, q[0].x});
                end
                check("match_cnt", {16'd0, match_cnt}, cnt16);
                check("sat_match_cnt", {28'd0, match_cnt_s}, cnt4);
                ofire = exp_ov && out_ready;
                if (ofire) begin
                    obs.push_back('{out_x, out_y, cyc});
                    if (q[0].x == {W{1'b1}}) begin
                        if (cnt16 < 65535) cnt16++;
                        if (cnt4 < 15) cnt4++;
                    end
                    void'(q.pop_front());
                end
                if (clr_cnt) begin
                    cnt16 = 0;
                    cnt4 = 0;
                end
                if (in_valid && exp_ir) begin
                    r = ref_xy(in_mode, in_a, in_b, in_c);
                    q.push_back('{r[2*W-1:W], r[W-1:0], cyc});
                end
                cyc++;
            end
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] a, b, c, input logic [1:0] m);
        in_valid = v;
        in_a = a;
        in_b = b;
        in_c = c;
        in_mode = m;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        step(3);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_x", {24'd0, out_x}, 0);
        check("rst_out_y", {24'd0, out_y}, 0);
        check("rst_match_cnt", {16'd0, match_cnt}, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step(2);
        check("idle_in_ready", {31'd0, in_ready}, 1);

        obs.delete();
        for (int m = 0; m < 4; m++) begin
            drive(1'b1, 8'hF0, 8'hCC, 8'hAA, 2'(m));
            step(1);
        end
        in_valid = 1'b0;
        step(4);
        check("fn_count", obs.size(), 4);
        for (int j = 0; j < 4 && j < obs.size(); j++) begin
            check($sformatf("fn_x_m%0d", j), {24'd0, obs[j].x}, {24'd0, fx_lit[j]});
            check($sformatf("fn_y_m%0d", j), {24'd0, obs[j].y}, {24'd0, fy_lit[j]});
            check($sformatf("fn_nobubble_%0d", j), obs[j].t, obs[0].t + j);
        end

        out_ready = 1'b0;
        obs.delete();
        drive(1'b1, 8'h11, 8'h00, 8'h00, 2'd3);
        step(1);
        drive(1'b1, 8'h22, 8'h00, 8'h00, 2'd3);
        step(1);
        drive(1'b1, 8'h33, 8'h00, 8'h00, 2'd3);
        check("bp_in_ready_low", {31'd0, in_ready}, 0);
        for (int k = 0; k < 5; k++) begin
            step(1);
            check("bp_hold_valid", {31'd0, out_valid}, 1);
            check("bp_hold_x", {24'd0, out_x}, 32'h11);
        end
        out_ready = 1'b1;
        step(1);
        in_valid = 1'b0;
        step(4);
        check("bp_count", obs.size(), 3);
        for (int j = 0; j < 3 && j < obs.size(); j++)
            check($sformatf("bp_order_%0d", j), {24'd0, obs[j].x}, {24'd0, bp_lit[j]});

        clr_cnt = 1'b1;
        step(1);
        clr_cnt = 1'b0;
        check("cnt_cleared", {16'd0, match_cnt}, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'h00, 8'h00, 8'h00, 2'd0);
            step(1);
        end
        in_valid = 1'b0;
        step(4);
        check("cnt_three", {16'd0, match_cnt}, 3);
        drive(1'b1, 8'h00, 8'h00, 8'h00, 2'd0);
        step(1);
        in_valid = 1'b0;
        step(1);
        check("cnt_fourth_valid", {31'd0, out_valid}, 1);
        clr_cnt = 1'b1;
        step(1);
        clr_cnt = 1'b0;
        check("cnt_clear_beats_inc", {16'd0, match_cnt}, 0);

        for (int k = 0; k < 17; k++) begin
            drive(1'b1, 8'h00, 8'h00, 8'h00, 2'd2);
            step(1);
        end
        in_valid = 1'b0;
        step(4);
        check("sat_at_15", {28'd0, match_cnt_s}, 15);
        check("wide_at_17", {16'd0, match_cnt}, 17);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'h00, 8'h00, 8'h00, 2'd0);
            step(1);
        end
        in_valid = 1'b0;
        step(4);
        check("sat_stays_15", {28'd0, match_cnt_s}, 15);
        check("wide_at_20", {16'd0, match_cnt}, 20);

        out_ready = 1'b0;
        drive(1'b1, 8'h5A, 8'h01, 8'h00, 2'd3);
        step(1);
        drive(1'b1, 8'hA5, 8'h02, 8'h00, 2'd3);
        step(1);
        in_valid = 1'b0;
        step(1);
        check("mid_full_valid", {31'd0, out_valid}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 0);
        check("mid_rst_x", {24'd0, out_x}, 0);
        check("mid_rst_y", {24'd0, out_y}, 0);
        check("mid_rst_cnt", {16'd0, match_cnt}, 0);
        check("mid_rst_sat_cnt", {28'd0, match_cnt_s}, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step(1);
        drive(1'b1, 8'h3C, 8'h0F, 8'hFF, 2'd1);
        step(1);
        in_valid = 1'b0;
        step(1);
        check("post_rst_valid", {31'd0, out_valid}, 1);
        check("post_rst_x", {24'd0, out_x}, 32'hF3);
        check("post_rst_y", {24'd0, out_y}, 32'h33);
        step(2);

        for (int k = 0; k < 3000; k++) begin
            if (k % 64 == 0) out_ready = 1'b0;
            if (k % 64 == 0 && $urandom_range(0, 2) != 0) out_ready = 1'b1;
            else if ($urandom_range(0, 3) == 0) out_ready = ~out_ready;
            drive($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), W'($urandom),
                  2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) drive(in_valid, 8'h00, 8'h00, 8'h00, 2'd2);
            clr_cnt = ($urandom_range(0, 63) == 0);
            step(1);
        end
        in_valid = 1'b0;
        clr_cnt = 1'b0;
        out_ready = 1'b1;
        step(5);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
